id_inst_queue: RTL and testbench



---
 rtl/cpu_defs_pkg.sv | 46 ++++
 rtl/id_inst_queue_if.sv | 48 ++++
 rtl/id_inst_queue_fields.sv | 38 +++
 rtl/id_inst_queue.sv | 96 +++++++++
 tb/tb_id_inst_queue.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared MIPS instruction-word field positions, widths and word type used by
// the IF/ID instruction queue and any stage that needs to split an instruction.
package cpu_defs_pkg;

    localparam int INST_W = 32;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SA_HI     = 10;
    localparam int SA_LO     = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int INDEX_HI  = 25;
    localparam int INDEX_LO  = 0;
    localparam int CODE_HI   = 25;
    localparam int CODE_LO   = 6;
    localparam int SEL_HI    = 2;
    localparam int SEL_LO    = 0;

    localparam int OPCODE_W = OPCODE_HI - OPCODE_LO + 1;
    localparam int REG_W    = RS_HI - RS_LO + 1;
    localparam int SA_W     = SA_HI - SA_LO + 1;
    localparam int FUNCT_W  = FUNCT_HI - FUNCT_LO + 1;
    localparam int IMM_W    = IMM_HI - IMM_LO + 1;
    localparam int INDEX_W  = INDEX_HI - INDEX_LO + 1;
    localparam int CODE_W   = CODE_HI - CODE_LO + 1;
    localparam int SEL_W    = SEL_HI - SEL_LO + 1;

    typedef logic [INST_W-1:0] inst_t;

    // Queue entry at the default 32-bit PC width; the queue derives its own
    // entry type when PC_W is overridden.
    typedef struct packed {
        logic [31:0] pc;
        inst_t       inst;
    } queue_entry_t;

endpackage

// File: rtl/id_inst_queue_if.sv
// Bundle of IF-side push, ID-side head/pop and flush signals of the instruction queue.
interface id_inst_queue_if
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int XLEN  = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; ready never depends combinationally on the partner's valid/ready.
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [PC_W-1:0]     in_pc;
    inst_t               in_inst;
    logic                out_valid;
    logic                out_ready;
    logic [PC_W-1:0]     out_pc;
    inst_t               out_inst;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [SA_W-1:0]     sa;
    logic [IMM_W-1:0]    imm;
    logic [XLEN-1:0]     imm_sext;
    logic [XLEN-1:0]     imm_zext;
    logic [INDEX_W-1:0]  inst_index;
    logic [CODE_W-1:0]   code;
    logic [SEL_W-1:0]    sel;
    logic [CNT_W-1:0]    count;

    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, opcode, funct, rs, rt, rd,
               sa, imm, imm_sext, imm_zext, inst_index, code, sel, count
    );

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, opcode, funct, rs, rt, rd,
               sa, imm, imm_sext, imm_zext, inst_index, code, sel, count
    );

endinterface

// File: rtl/id_inst_queue_fields.sv
// Combinational splitter of one 32-bit MIPS word into its named fields, with
// sign- and zero-extended immediates. Reusable by any pipeline stage.
module inst_fields
    import cpu_defs_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  inst_t               inst,
    output logic [OPCODE_W-1:0] opcode,
    output logic [FUNCT_W-1:0]  funct,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [SA_W-1:0]     sa,
    output logic [IMM_W-1:0]    imm,
    output logic [XLEN-1:0]     imm_sext,
    output logic [XLEN-1:0]     imm_zext,
    output logic [INDEX_W-1:0]  inst_index,
    output logic [CODE_W-1:0]   code,
    output logic [SEL_W-1:0]    sel
);

    assign opcode     = inst[OPCODE_HI:OPCODE_LO];
    assign funct      = inst[FUNCT_HI:FUNCT_LO];
    assign rs         = inst[RS_HI:RS_LO];
    assign rt         = inst[RT_HI:RT_LO];
    assign rd         = inst[RD_HI:RD_LO];
    assign sa         = inst[SA_HI:SA_LO];
    assign imm        = inst[IMM_HI:IMM_LO];
    assign inst_index = inst[INDEX_HI:INDEX_LO];
    assign code       = inst[CODE_HI:CODE_LO];
    assign sel        = inst[SEL_HI:SEL_LO];

    // Size casts keep XLEN == 16 legal (no zero-width replication).
    assign imm_sext = XLEN'($signed(inst[IMM_HI:IMM_LO]));
    assign imm_zext = XLEN'(inst[IMM_HI:IMM_LO]);

endmodule

// File: rtl/id_inst_queue.sv
// IF->ID instruction queue: DEPTH-entry circular buffer of {pc, inst} pairs
// with registered-only ready, no empty bypass, and flush of wrong-path entries.
module id_inst_queue
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int XLEN  = 32
) (
    input logic            clk,
    input logic            resetn,
    id_inst_queue_if.slave q
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        inst_t           inst;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    entry_t           head;

    // Full/empty come from the occupancy register only, so in_ready has no
    // path from out_ready: a full queue refuses a push even while popping.
    assign full  = (occupancy == CNT_W'(DEPTH));
    assign empty = (occupancy == '0);
    assign push  = q.in_valid && !full;
    assign pop   = q.out_ready && !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (q.flush) begin
            // Storage is kept; only the bookkeeping forgets the entries.
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: q.in_pc, inst: q.in_inst};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head        = mem[rd_ptr];
    assign q.in_ready  = !full;
    assign q.out_valid = !empty;
    assign q.out_pc    = head.pc;
    assign q.out_inst  = head.inst;
    assign q.count     = occupancy;

    inst_fields #(
        .XLEN(XLEN)
    ) u_fields (
        .inst      (head.inst),
        .opcode    (q.opcode),
        .funct     (q.funct),
        .rs        (q.rs),
        .rt        (q.rt),
        .rd        (q.rd),
        .sa        (q.sa),
        .imm       (q.imm),
        .imm_sext  (q.imm_sext),
        .imm_zext  (q.imm_zext),
        .inst_index(q.inst_index),
        .code      (q.code),
        .sel       (q.sel)
    );

    a_count_bound : assert property (@(posedge clk) disable iff (!resetn)
        occupancy <= CNT_W'(DEPTH));

    a_head_stable : assert property (@(posedge clk) disable iff (!resetn)
        (q.out_valid && !q.out_ready && !q.flush) |=> $stable(head));

endmodule

// File: tb/tb_id_inst_queue.sv
// Randomised + directed bench for id_inst_queue with a queue-based reference model.
module tb_id_inst_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int XLEN  = 32;
    localparam int W     = PC_W + 32;

    logic clk;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [W-1:0] exp_q[$];

    id_inst_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .XLEN(XLEN)) q ();

    id_inst_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .XLEN(XLEN)) dut (
        .clk   (clk),
        .resetn(resetn),
        .q     (q)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference field decode from the MIPS bit layout
    task automatic check_head(input logic [W-1:0] e);
        logic [63:0] inst;
        logic [63:0] imm;
        inst = 64'(e[31:0]);
        imm  = inst & 64'hFFFF;
        check("out_pc", 64'(q.out_pc), 64'(e[W-1:32]));
        check("out_inst", 64'(q.out_inst), inst);
        check("opcode", 64'(q.opcode), (inst >> 26) & 64'h3F);
        check("funct", 64'(q.funct), inst & 64'h3F);
        check("rs", 64'(q.rs), (inst >> 21) & 64'h1F);
        check("rt", 64'(q.rt), (inst >> 16) & 64'h1F);
        check("rd", 64'(q.rd), (inst >> 11) & 64'h1F);
        check("sa", 64'(q.sa), (inst >> 6) & 64'h1F);
        check("imm", 64'(q.imm), imm);
        check("imm_sext", 64'(q.imm_sext), (imm >= 64'h8000) ? (imm + 64'hFFFF_0000) : imm);
        check("imm_zext", 64'(q.imm_zext), imm);
        check("inst_index", 64'(q.inst_index), inst & 64'h3FF_FFFF);
        check("code", 64'(q.code), (inst >> 6) & 64'hF_FFFF);
        check("sel", 64'(q.sel), inst & 64'h7);
    endtask

    // monitor + scoreboard: checks the presented state, then applies the
    // effect the upcoming edge must have on the reference queue
    always @(negedge clk) begin
        logic do_push;
        logic do_pop;
        if (!resetn) begin
            check("rst_out_valid", 64'(q.out_valid), 64'd0);
            check("rst_in_ready", 64'(q.in_ready), 64'd1);
            check("rst_count", 64'(q.count), 64'd0);
            check("rst_out_pc", 64'(q.out_pc), 64'd0);
            check("rst_out_inst", 64'(q.out_inst), 64'd0);
            exp_q.delete();
        end else begin
            check("count", 64'(q.count), 64'(exp_q.size()));
            check("in_ready", 64'(q.in_ready), 64'(exp_q.size() < DEPTH));
            check("out_valid", 64'(q.out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) check_head(exp_q[0]);
            if (q.flush) begin
                exp_q.delete();
            end else begin
                do_push = q.in_valid && (exp_q.size() < DEPTH);
                do_pop  = q.out_ready && (exp_q.size() != 0);
                if (do_pop) void'(exp_q.pop_front());
                if (do_push) exp_q.push_back({q.in_pc, q.in_inst});
            end
        end
    end

    // driver: called at posedge+1, applies inputs, returns at next posedge+1
    task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic fl);
        q.in_valid  = v;
        q.in_pc     = pc;
        q.in_inst   = inst;
        q.out_ready = rdy;
        q.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, '0, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.out_valid; i++) idle(1'b1);
        check("drain_empty", 64'(q.out_valid), 64'd0);
    endtask

    initial begin
        logic [PC_W-1:0] pc;
        resetn      = 1'b0;
        q.in_valid  = 1'b0;
        q.in_pc     = '0;
        q.in_inst   = '0;
        q.out_ready = 1'b0;
        q.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1'b0);

        // lw sp-relative, held at the head
        step(1'b1, 32'hBFC0_0000, 32'h8FA4_0010, 1'b0, 1'b0);
        check("d1_out_valid", 64'(q.out_valid), 64'd1);
        check("d1_opcode", 64'(q.opcode), 64'h23);
        check("d1_rs", 64'(q.rs), 64'd29);
        check("d1_rt", 64'(q.rt), 64'd4);
        check("d1_imm", 64'(q.imm), 64'h0010);
        check("d1_imm_sext", 64'(q.imm_sext), 64'h0000_0010);
        check("d1_count", 64'(q.count), 64'd1);
        idle(1'b0);
        idle(1'b1);

        // addiu with negative immediate
        step(1'b1, 32'hBFC0_0004, 32'h2408_FFFF, 1'b0, 1'b0);
        check("d2_opcode", 64'(q.opcode), 64'h09);
        check("d2_rs", 64'(q.rs), 64'd0);
        check("d2_rt", 64'(q.rt), 64'd8);
        check("d2_imm_sext", 64'(q.imm_sext), 64'hFFFF_FFFF);
        check("d2_imm_zext", 64'(q.imm_zext), 64'h0000_FFFF);
        check("d2_inst_index", 64'(q.inst_index), 64'h008_FFFF);
        idle(1'b1);

        // fill to full, then push refused while a pop happens
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + 32'(i * 4), $urandom, 1'b0, 1'b0);
        check("full_count", 64'(q.count), 64'(DEPTH));
        check("full_in_ready", 64'(q.in_ready), 64'd0);
        step(1'b1, 32'h200, 32'h0000_0021, 1'b1, 1'b0);
        check("full_pop_count", 64'(q.count), 64'(DEPTH - 1));
        step(1'b1, 32'h200, 32'h0000_0021, 1'b0, 1'b0);
        check("refill_count", 64'(q.count), 64'(DEPTH));
        drain();

        // random stream with occasional flush
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, pc, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 39) == 0);
            pc = pc + 4;
        end
        drain();

        // flush with a concurrent push and pop
        for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(i * 4), $urandom, 1'b0, 1'b0);
        check("pre_flush_count", 64'(q.count), 64'd3);
        step(1'b1, 32'h400, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check("flush_count", 64'(q.count), 64'd0);
        check("flush_out_valid", 64'(q.out_valid), 64'd0);
        check("flush_in_ready", 64'(q.in_ready), 64'd1);
        idle(1'b0);
        check("flush_push_absent", 64'(q.out_valid), 64'd0);

        // asynchronous reset between edges
        for (int i = 0; i < 2; i++) step(1'b1, 32'h500 + 32'(i * 4), $urandom, 1'b0, 1'b0);
        check("pre_rst_count", 64'(q.count), 64'd2);
        q.in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("async_out_valid", 64'(q.out_valid), 64'd0);
        check("async_count", 64'(q.count), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1'b0);
        check("post_rst_count", 64'(q.count), 64'd0);

        // short stream after reset
        for (int i = 0; i < 30; i++) begin
            step($urandom_range(0, 1) == 1, 32'h600 + 32'(i * 4), $urandom,
                 1'($urandom_range(0, 1)), 1'b0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
